// File: rtl/intr_ctrl_pkg.sv
// Shared definitions for the interrupt controller, its control-unit peer and
// the assembler memory map.
//   - FSM state encoding (legacy-compatible 2-bit constants)
//   - source-count limit and source-index width
//   - default handler vector base and stride
//   - helper that turns a source index into a vector offset
package intr_pkg;

  localparam int N_SRC_MAX = 8;
  localparam int ID_W      = 3;

  localparam logic [9:0] VEC_BASE_DEF   = 10'h3C0;
  localparam int         VEC_STRIDE_DEF = 16;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_REQ     = 2'd1;
  localparam logic [1:0] ST_SERVICE = 2'd2;

  typedef logic [ID_W-1:0] src_id_t;

  // Byte distance of a source's handler from the vector base.
  function automatic int vec_offset(input src_id_t id, input int stride);
    return int'(id) * stride;
  endfunction

endpackage

// File: rtl/intr_ctrl_if.sv
// Bundle of signals between the interrupt controller, the I/O sources and the
// CPU control unit.
//   master : the CPU/system side (drives source lines, mask writes, ack, eoi)
//   slave  : the controller (drives request, vector, id and status)
interface intr_ctrl_if #(
  parameter int N_SRC = 4,
  parameter int AW    = 10
);
  import intr_pkg::*;

  logic [N_SRC-1:0] irq_src;
  logic             mask_we;
  logic [N_SRC-1:0] mask_din;
  logic             cpu_ack;
  logic             cpu_eoi;
  logic             irq_req;
  logic [AW-1:0]    irq_vector;
  src_id_t          irq_id;
  logic [N_SRC-1:0] pending;
  logic [N_SRC-1:0] mask;
  logic             busy;

  modport master (
    output irq_src, mask_we, mask_din, cpu_ack, cpu_eoi,
    input  irq_req, irq_vector, irq_id, pending, mask, busy
  );

  modport slave (
    input  irq_src, mask_we, mask_din, cpu_ack, cpu_eoi,
    output irq_req, irq_vector, irq_id, pending, mask, busy
  );

endinterface

// File: rtl/intr_ctrl_prio_enc.sv
// Fixed-priority encoder: returns the index of the lowest set request bit.
//   req   : request vector, bit 0 has the highest priority
//   idx   : index of the winning bit (0 when nothing is requested)
//   valid : at least one bit of req is set
module prio_enc
  import intr_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0] req,
  output src_id_t      idx,
  output logic         valid
);

  // Scan from the top down so the lowest set index is the last to write.
  always_comb begin
    idx   = '0;
    valid = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        idx   = src_id_t'(i);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/intr_ctrl.sv
// Interrupt controller: captures rising edges on the source lines, masks and
// prioritises them, and runs one request/service handshake at a time with the
// CPU control unit.
//   clk   : system clock, rising edge
//   reset : synchronous, active-high
//   bus   : slave side of intr_ctrl_if (source lines, mask write, cpu_ack,
//           cpu_eoi in; irq_req, irq_vector, irq_id, pending, mask, busy out)
module intr_ctrl
  import intr_pkg::*;
#(
  parameter int            N_SRC      = 4,
  parameter int            AW         = 10,
  parameter logic [AW-1:0] VEC_BASE   = AW'(VEC_BASE_DEF),
  parameter int            VEC_STRIDE = VEC_STRIDE_DEF
) (
  input logic        clk,
  input logic        reset,
  intr_ctrl_if.slave bus
);

  logic [1:0]       state_reg;
  logic [N_SRC-1:0] prev_reg;
  logic [N_SRC-1:0] pending_reg;
  logic [N_SRC-1:0] mask_reg;
  logic             irq_req_reg;
  logic             busy_reg;
  src_id_t          irq_id_reg;
  logic [AW-1:0]    irq_vector_reg;

  logic [N_SRC-1:0] rise;
  logic [N_SRC-1:0] clr;
  logic [N_SRC-1:0] pending_next;
  logic [N_SRC-1:0] eligible;
  src_id_t          win_id;
  logic             win_valid;
  logic [AW-1:0]    vec_next;

  assign rise     = bus.irq_src & ~prev_reg;
  assign eligible = pending_reg & mask_reg;

  // A source is cleared only by the ack of its own grant; a rise in the same
  // cycle is a fresh event and re-sets the bit.
  for (genvar gi = 0; gi < N_SRC; gi++) begin : g_clr
    assign clr[gi] = (state_reg == ST_REQ) && bus.cpu_ack &&
                     (irq_id_reg == src_id_t'(gi));
  end

  assign pending_next = (pending_reg & ~clr) | rise;

  prio_enc #(.N(N_SRC)) u_prio (
    .req   (eligible),
    .idx   (win_id),
    .valid (win_valid)
  );

  assign vec_next = VEC_BASE + AW'(vec_offset(win_id, VEC_STRIDE));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= ST_IDLE;
      prev_reg       <= '0;
      pending_reg    <= '0;
      mask_reg       <= '0;
      irq_req_reg    <= 1'b0;
      busy_reg       <= 1'b0;
      irq_id_reg     <= '0;
      irq_vector_reg <= '0;
    end else begin
      prev_reg    <= bus.irq_src;
      pending_reg <= pending_next;
      if (bus.mask_we) begin
        mask_reg <= bus.mask_din;
      end

      case (state_reg)
        ST_IDLE: begin
          // The grant is latched here and frozen until the CPU acks it.
          if (win_valid) begin
            irq_id_reg     <= win_id;
            irq_vector_reg <= vec_next;
            irq_req_reg    <= 1'b1;
            state_reg      <= ST_REQ;
          end
        end
        ST_REQ: begin
          // Ack takes precedence; an eoi in the same cycle is dropped.
          if (bus.cpu_ack) begin
            irq_req_reg <= 1'b0;
            busy_reg    <= 1'b1;
            state_reg   <= ST_SERVICE;
          end
        end
        ST_SERVICE: begin
          if (bus.cpu_eoi) begin
            busy_reg  <= 1'b0;
            state_reg <= ST_IDLE;
          end
        end
        default: begin
          irq_req_reg <= 1'b0;
          busy_reg    <= 1'b0;
          state_reg   <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.irq_req    = irq_req_reg;
  assign bus.irq_vector = irq_vector_reg;
  assign bus.irq_id     = irq_id_reg;
  assign bus.pending    = pending_reg;
  assign bus.mask       = mask_reg;
  assign bus.busy       = busy_reg;

endmodule

// File: tb/tb_intr_ctrl.sv
// Self-checking bench for intr_ctrl. Stimulus pushes the expected grant
// (id, vector, cycle of irq_req rising) into a scoreboard queue; a monitor
// on the falling edge pops and compares whenever a new request appears.
// Status registers are checked inline against hand-computed values.
module tb_intr_ctrl;
  import intr_pkg::*;

  typedef struct {
    int id;
    int vec;
    int cyc;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_miss = 0;
  exp_t sb_q[$];

  intr_ctrl_if #(.N_SRC(4), .AW(10)) bus ();

  intr_ctrl #(
    .N_SRC      (4),
    .AW         (10),
    .VEC_BASE   (10'h3C0),
    .VEC_STRIDE (16)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_exp(input int id, input int vec, input int at);
    exp_t e;
    e.id = id;
    e.vec = vec;
    e.cyc = at;
    sb_q.push_back(e);
  endtask

  task automatic wait_req();
    int n = 0;
    while (bus.irq_req !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    n_vec++;
    if (bus.irq_req !== 1'b1) begin
      n_miss++;
      $display("FAIL wait_req: irq_req got %b expected 1 within 20 cycles", bus.irq_req);
    end
  endtask

  task automatic do_ack();
    bus.cpu_ack = 1'b1;
    step();
    bus.cpu_ack = 1'b0;
  endtask

  task automatic do_eoi();
    bus.cpu_eoi = 1'b1;
    step();
    bus.cpu_eoi = 1'b0;
  endtask

  task automatic write_mask(input logic [3:0] v);
    bus.mask_we  = 1'b1;
    bus.mask_din = v;
    step();
    bus.mask_we  = 1'b0;
  endtask

  // Monitor: one scoreboard pop per new request.
  logic last_req = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (bus.irq_req === 1'b1 && last_req !== 1'b1) begin
      $display("request id=%0d vector=%h cyc=%0d", bus.irq_id, bus.irq_vector, cyc);
      if (sb_q.size() == 0) begin
        n_vec++;
        n_miss++;
        $display("FAIL unexpected_req: got id %0d expected no request", bus.irq_id);
      end else begin
        e = sb_q.pop_front();
        check("grant_id", 32'(bus.irq_id), 32'(e.id));
        check("grant_vec", 32'(bus.irq_vector), 32'(e.vec));
        check("grant_cyc", 32'(cyc), 32'(e.cyc));
      end
    end
    last_req = bus.irq_req;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    bus.irq_src  = '0;
    bus.mask_we  = 1'b0;
    bus.mask_din = '0;
    bus.cpu_ack  = 1'b0;
    bus.cpu_eoi  = 1'b0;
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    step();

    // Reset state
    check("rst_pending", 32'(bus.pending), 32'h0);
    check("rst_mask", 32'(bus.mask), 32'h0);
    check("rst_req", 32'(bus.irq_req), 32'h0);
    check("rst_busy", 32'(bus.busy), 32'h0);
    check("rst_id", 32'(bus.irq_id), 32'h0);
    check("rst_vec", 32'(bus.irq_vector), 32'h0);

    // Basic request/service on source 2
    write_mask(4'b1111);
    check("mask_f", 32'(bus.mask), 32'hF);
    k = cyc;
    push_exp(2, 'h3E0, k + 2);
    bus.irq_src = 4'b0100;
    step();
    bus.irq_src = '0;
    check("t1_pending", 32'(bus.pending), 32'h4);
    wait_req();
    do_ack();
    check("t1_ack_pending", 32'(bus.pending), 32'h0);
    check("t1_ack_busy", 32'(bus.busy), 32'h1);
    check("t1_ack_req", 32'(bus.irq_req), 32'h0);
    do_eoi();
    check("t1_eoi_busy", 32'(bus.busy), 32'h0);

    // Masked source stays pending, fires after unmask
    write_mask(4'b0000);
    bus.irq_src = 4'b0010;
    step();
    bus.irq_src = '0;
    step();
    step();
    check("t2_pending", 32'(bus.pending), 32'h2);
    check("t2_req_masked", 32'(bus.irq_req), 32'h0);
    push_exp(1, 'h3D0, cyc + 2);
    write_mask(4'b0010);
    wait_req();
    do_ack();
    do_eoi();
    write_mask(4'b1111);

    // Simultaneous 3 and 0: 0 first, then 3 without new stimulus
    k = cyc;
    push_exp(0, 'h3C0, k + 2);
    bus.irq_src = 4'b1001;
    step();
    bus.irq_src = '0;
    check("t3_pending", 32'(bus.pending), 32'h9);
    wait_req();
    do_ack();
    push_exp(3, 'h3F0, cyc + 2);
    do_eoi();
    wait_req();
    do_ack();
    do_eoi();

    // Higher priority arrival during REQ does not change the grant
    k = cyc;
    push_exp(2, 'h3E0, k + 2);
    bus.irq_src = 4'b0100;
    step();
    bus.irq_src = '0;
    wait_req();
    bus.irq_src = 4'b0001;
    step();
    bus.irq_src = '0;
    step();
    check("t4_id_held", 32'(bus.irq_id), 32'h2);
    check("t4_req_held", 32'(bus.irq_req), 32'h1);
    check("t4_pending", 32'(bus.pending), 32'h5);
    do_ack();
    check("t4_ack_pending", 32'(bus.pending), 32'h1);
    push_exp(0, 'h3C0, cyc + 2);
    do_eoi();
    wait_req();
    do_ack();
    do_eoi();

    // Rise on the granted source in its ack cycle: set wins
    k = cyc;
    push_exp(1, 'h3D0, k + 2);
    bus.irq_src = 4'b0010;
    step();
    bus.irq_src = '0;
    wait_req();
    bus.cpu_ack = 1'b1;
    bus.irq_src = 4'b0010;
    step();
    bus.cpu_ack = 1'b0;
    bus.irq_src = '0;
    check("t5_pending_kept", 32'(bus.pending), 32'h2);
    check("t5_busy", 32'(bus.busy), 32'h1);
    push_exp(1, 'h3D0, cyc + 2);
    do_eoi();
    wait_req();
    do_ack();
    do_eoi();

    // Mask cleared while in REQ: grant still completes
    k = cyc;
    push_exp(2, 'h3E0, k + 2);
    bus.irq_src = 4'b0100;
    step();
    bus.irq_src = '0;
    wait_req();
    write_mask(4'b0000);
    check("t6_mask0", 32'(bus.mask), 32'h0);
    check("t6_req_stays", 32'(bus.irq_req), 32'h1);
    do_ack();
    check("t6_busy", 32'(bus.busy), 32'h1);
    do_eoi();
    write_mask(4'b1111);

    // Reset during SERVICE with source 3 pending
    k = cyc;
    push_exp(0, 'h3C0, k + 2);
    bus.irq_src = 4'b0001;
    step();
    bus.irq_src = '0;
    wait_req();
    do_ack();
    bus.irq_src = 4'b1000;
    step();
    bus.irq_src = '0;
    check("t7_pending", 32'(bus.pending), 32'h8);
    check("t7_busy", 32'(bus.busy), 32'h1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("t7_rst_pending", 32'(bus.pending), 32'h0);
    check("t7_rst_mask", 32'(bus.mask), 32'h0);
    check("t7_rst_busy", 32'(bus.busy), 32'h0);
    check("t7_rst_req", 32'(bus.irq_req), 32'h0);
    check("t7_rst_id", 32'(bus.irq_id), 32'h0);
    check("t7_rst_vec", 32'(bus.irq_vector), 32'h0);
    bus.cpu_eoi = 1'b1;
    bus.cpu_ack = 1'b1;
    step();
    bus.cpu_eoi = 1'b0;
    bus.cpu_ack = 1'b0;
    step();
    step();
    check("t7_stray_busy", 32'(bus.busy), 32'h0);
    check("t7_stray_req", 32'(bus.irq_req), 32'h0);

    repeat (4) step();
    check("sb_empty", 32'(sb_q.size()), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
